red_pitaya_asg_burst_ch: RTL
============================

// Module: red_pitaya_asg_burst_ch
// PURPOSE
//   Parametrised next-generation ASG channel: table-based arbitrary waveform playback with
//   fractional phase stepping, gain/offset scaling and saturation, driving one DAC lane.
//   Adds an explicit burst FSM: N table periods per burst, M repetitions, clock-accurate
//   inter-burst delay, and idle-output hold. Sits between the ASG register bank and the DAC mux.
// PARAMETERS
//   DW         14  DAC/table sample width (signed two's complement)
//   RSZ        14  table address bits; depth = 2**RSZ
//   FRAC       16  fractional pointer bits
//   CYCLE_BITS 32  width of periods-per-burst counter
//   REP_BITS   16  width of repetition counter
//   TICK_DIV   125 clocks per inter-burst delay tick (1 = per-clock delay)
// PORTS
//   dac_clk_i    in  1           clock
//   dac_rstn_i   in  1           reset, asynchronous, active-low
//   trig_sw_i    in  1           software trigger pulse
//   trig_ext_i   in  1           external trigger level, already synchronised
//   trig_src_i   in  2           0 off, 1 sw, 2 ext rising, 3 ext falling
//   buf_we_i     in  1           table write enable
//   buf_addr_i   in  RSZ         table write address
//   buf_wdata_i  in  DW          table write data
//   set_size_i   in  RSZ+FRAC    last valid pointer value (length*2**FRAC - 1)
//   set_step_i   in  RSZ+FRAC    pointer increment per clock
//   set_ofs_i    in  RSZ+FRAC    start pointer
//   set_amp_i    in  DW          unsigned gain, 1.0 = 2**(DW-1)
//   set_dc_i     in  DW          signed output offset
//   set_ncyc_i   in  CYCLE_BITS  table periods per burst; 0 = run until set_rst_i
//   set_rnum_i   in  REP_BITS    extra bursts after the first; 0 = single burst
//   set_rdly_i   in  32          ticks between bursts
//   set_wrap_i   in  1           1: wrap keeps remainder; 0: wrap reloads set_ofs_i
//   set_hold_i   in  1           1: hold last sample when idle; 0: output sat(dc) when idle
//   set_rst_i    in  1           synchronous abort to IDLE
//   dac_o        out DW          DAC sample
//   buf_rpnt_o   out RSZ         integer part of current pointer
//   busy_o       out 1           high in RUN and DELAY
//   trig_done_o  out 1           one-cycle pulse at every burst start (incl. repetitions)
// BEHAVIOUR
//   Reset (async, dac_rstn_i=0): state IDLE, pointer/counters 0, dac_o=0, buf_rpnt_o=0,
//     busy_o=0, trig_done_o=0, pipeline valids 0, ext edge register 0. Applies immediately.
//   FSM IDLE->RUN on selected trigger (ext edges from one-register edge detect); triggers
//     ignored outside IDLE. RUN entry: pnt<=set_ofs_i, cyc<=set_ncyc_i, trig_done_o=1.
//   RUN: npnt=pnt+set_step_i (RSZ+FRAC+1 bits); if npnt>set_size_i -> period end:
//     pnt<=set_wrap_i ? npnt-set_size_i-1 : set_ofs_i; else pnt<=npnt.
//     Period end with cyc==1 ends burst: rep>0 and set_rdly_i>0 -> DELAY;
//     rep>0 and set_rdly_i==0 -> RUN restart next cycle (rep--, trig_done_o);
//     rep==0 -> IDLE. ncyc==0: cyc never decrements, burst endless.
//   rep loaded from set_rnum_i on IDLE->RUN only.
//   DELAY: tick divider counts TICK_DIV clocks per tick; after set_rdly_i ticks -> RUN
//     restart (pnt<=ofs, cyc reload, rep--, trig_done_o). Divider cleared on DELAY entry.
//   set_rst_i: any state -> IDLE next edge, pnt<=set_ofs_i, no trig_done_o; beats a
//     same-cycle trigger. In-flight pipeline samples still complete.
//   Pipeline: pnt -> addr reg -> RAM reg -> mult reg -> sum reg -> dac_o; sample at pnt
//     appears on dac_o 5 edges after pnt holds it. Valid bit accompanies each stage.
//   Scaling: prod = sample(s,DW) * {0,amp}(s,DW+1); scaled = prod>>>(DW-1);
//     sum = scaled + dc, DW+2 bits signed; saturate to [-2**(DW-1), 2**(DW-1)-1].
//   dac_o stage: valid -> sat(sum); not valid -> hold ? keep : sat(dc).
//   Table write: one port, any state; same-address read during write returns old data.
//   buf_rpnt_o = pnt[RSZ+FRAC-1:FRAC], registered. busy_o registered from state.
// TESTING
//   T1 DW=14,FRAC=16: table ramp 0..7, size=(8<<16)-1, step=1<<16, ofs=0, amp=8192,
//      ncyc=2, sw trig -> dac_o 0..7,0..7 from trigger edge+6, busy 16 cycles, then dc=0.
//   T2 T1 + rnum=2, rdly=3, TICK_DIV=1 -> 3 bursts, 3 trig_done_o pulses, 3-cycle gaps.
//   T3 sample 8191, amp=16383, dc=8191 -> 8191; sample -8192, dc=-8192 -> -8192.
//   T4 step=3<<16, size=(8<<16)-1: wrap=1 addr 0,3,6,1,4,7,2,5; wrap=0 addr 0,3,6,0,3,6.
//   T5 ncyc=0 running; set_rst_i with ext rising edge same cycle -> IDLE, busy_o 0, no pulse.
//   T6 dac_rstn_i low mid-RUN -> dac_o/busy_o 0 before next edge; restart after release OK.

Source files
------------

// File: rtl/red_pitaya_asg_burst_ch.sv
// ASG channel: table playback with fractional stepping, gain/offset/saturation and a
// burst FSM (periods per burst, repetitions, tick-based inter-burst delay, idle hold).
module red_pitaya_asg_burst_ch #(
  parameter int DW         = 14,
  parameter int RSZ        = 14,
  parameter int FRAC       = 16,
  parameter int CYCLE_BITS = 32,
  parameter int REP_BITS   = 16,
  parameter int TICK_DIV   = 125
) (
  input  logic                  dac_clk_i,
  input  logic                  dac_rstn_i,
  input  logic                  trig_sw_i,
  input  logic                  trig_ext_i,
  input  logic [1:0]            trig_src_i,
  input  logic                  buf_we_i,
  input  logic [RSZ-1:0]        buf_addr_i,
  input  logic [DW-1:0]         buf_wdata_i,
  input  logic [RSZ+FRAC-1:0]   set_size_i,
  input  logic [RSZ+FRAC-1:0]   set_step_i,
  input  logic [RSZ+FRAC-1:0]   set_ofs_i,
  input  logic [DW-1:0]         set_amp_i,
  input  logic [DW-1:0]         set_dc_i,
  input  logic [CYCLE_BITS-1:0] set_ncyc_i,
  input  logic [REP_BITS-1:0]   set_rnum_i,
  input  logic [31:0]           set_rdly_i,
  input  logic                  set_wrap_i,
  input  logic                  set_hold_i,
  input  logic                  set_rst_i,
  output logic [DW-1:0]         dac_o,
  output logic [RSZ-1:0]        buf_rpnt_o,
  output logic                  busy_o,
  output logic                  trig_done_o
);

  localparam int PW   = RSZ + FRAC;
  localparam int DIVW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DELAY = 2'd2;

  function automatic logic signed [DW-1:0] sat_dw(input logic signed [DW+1:0] v);
    if (v > $signed({3'b000, {(DW-1){1'b1}}}))
      return {1'b0, {(DW-1){1'b1}}};
    else if (v < $signed({3'b111, {(DW-1){1'b0}}}))
      return {1'b1, {(DW-1){1'b0}}};
    else
      return v[DW-1:0];
  endfunction

  logic [1:0]            state_q, state_d;
  logic [PW-1:0]         pnt_q, pnt_d;
  logic [CYCLE_BITS-1:0] cyc_q, cyc_d;
  logic [REP_BITS-1:0]   rep_q, rep_d;
  logic [31:0]           dly_q, dly_d;
  logic [DIVW-1:0]       div_q, div_d;
  logic                  trig_q, trig_d;
  logic                  ext_q;
  logic                  done_q, done_d;
  logic                  busy_q;
  logic                  trig_sel;
  logic [PW:0]           npnt;
  logic [PW-1:0]         wpnt;
  logic                  pend;

  // Trigger source select; external edges come from a one-register edge detect
  always_comb begin
    trig_sel = 1'b0;
    case (trig_src_i)
      2'd1:    trig_sel = trig_sw_i;
      2'd2:    trig_sel = trig_ext_i & ~ext_q;
      2'd3:    trig_sel = ~trig_ext_i & ext_q;
      default: trig_sel = 1'b0;
    endcase
  end

  // Abort must also cancel a trigger captured in the same cycle
  assign trig_d = trig_sel & ~set_rst_i & (state_q == ST_IDLE);
  assign npnt   = {1'b0, pnt_q} + {1'b0, set_step_i};
  assign pend   = npnt > {1'b0, set_size_i};
  assign wpnt   = set_wrap_i ? (npnt[PW-1:0] - set_size_i - PW'(1)) : set_ofs_i;

  always_comb begin
    state_d = state_q;
    pnt_d   = pnt_q;
    cyc_d   = cyc_q;
    rep_d   = rep_q;
    dly_d   = dly_q;
    div_d   = div_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (trig_q) begin
          state_d = ST_RUN;
          pnt_d   = set_ofs_i;
          cyc_d   = set_ncyc_i;
          rep_d   = set_rnum_i;
          done_d  = 1'b1;
        end
      end
      ST_RUN: begin
        if (!pend) begin
          pnt_d = npnt[PW-1:0];
        end else begin
          pnt_d = wpnt;
          if (cyc_q == CYCLE_BITS'(1)) begin
            if (rep_q == '0) begin
              state_d = ST_IDLE;
            end else if (set_rdly_i == 32'd0) begin
              pnt_d  = set_ofs_i;
              cyc_d  = set_ncyc_i;
              rep_d  = rep_q - REP_BITS'(1);
              done_d = 1'b1;
            end else begin
              state_d = ST_DELAY;
              dly_d   = 32'd0;
              div_d   = '0;
            end
          end else if (cyc_q != '0) begin
            cyc_d = cyc_q - CYCLE_BITS'(1);
          end
        end
      end
      ST_DELAY: begin
        if (div_q == DIVW'(TICK_DIV - 1)) begin
          div_d = '0;
          if (dly_q + 32'd1 >= set_rdly_i) begin
            state_d = ST_RUN;
            pnt_d   = set_ofs_i;
            cyc_d   = set_ncyc_i;
            rep_d   = rep_q - REP_BITS'(1);
            done_d  = 1'b1;
          end else begin
            dly_d = dly_q + 32'd1;
          end
        end else begin
          div_d = div_q + DIVW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (set_rst_i) begin
      state_d = ST_IDLE;
      pnt_d   = set_ofs_i;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge dac_clk_i or negedge dac_rstn_i) begin
    if (!dac_rstn_i) begin
      state_q <= ST_IDLE;
      pnt_q   <= '0;
      cyc_q   <= '0;
      rep_q   <= '0;
      dly_q   <= '0;
      div_q   <= '0;
      trig_q  <= 1'b0;
      ext_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pnt_q   <= pnt_d;
      cyc_q   <= cyc_d;
      rep_q   <= rep_d;
      dly_q   <= dly_d;
      div_q   <= div_d;
      trig_q  <= trig_d;
      ext_q   <= trig_ext_i;
      done_q  <= done_d;
      busy_q  <= (state_q != ST_IDLE);
    end
  end

  logic signed [DW-1:0]   mem [0:(2**RSZ)-1];
  logic [RSZ-1:0]         addr_p0;
  logic signed [DW-1:0]   rdata_p1;
  logic signed [2*DW:0]   prod_p2;
  logic signed [DW+1:0]   sum_p3;
  logic signed [DW-1:0]   dac_q;
  logic                   vld_p0, vld_p1, vld_p2, vld_p3;
  logic signed [DW+1:0]   dc_ext;
  logic                   unused_prod;

  assign dc_ext      = {{2{set_dc_i[DW-1]}}, set_dc_i};
  assign unused_prod = ^prod_p2[DW-2:0];

  // p0: address capture | p1: table read | p2: gain | p3: offset | out: saturate/hold
  always_ff @(posedge dac_clk_i or negedge dac_rstn_i) begin
    if (!dac_rstn_i) begin
      addr_p0 <= '0;
      vld_p0  <= 1'b0;
      vld_p1  <= 1'b0;
      vld_p2  <= 1'b0;
      vld_p3  <= 1'b0;
      dac_q   <= '0;
    end else begin
      addr_p0 <= pnt_q[PW-1:FRAC];
      vld_p0  <= (state_q == ST_RUN);
      vld_p1  <= vld_p0;
      vld_p2  <= vld_p1;
      vld_p3  <= vld_p2;
      if (vld_p3)
        dac_q <= sat_dw(sum_p3);
      else if (!set_hold_i)
        dac_q <= sat_dw(dc_ext);
    end
  end

  // Read-before-write: a same-address read during a write returns the old word
  always_ff @(posedge dac_clk_i) begin
    if (buf_we_i)
      mem[buf_addr_i] <= buf_wdata_i;
    rdata_p1 <= mem[addr_p0];
    prod_p2  <= (2*DW+1)'(rdata_p1) * (2*DW+1)'($signed({1'b0, set_amp_i}));
    sum_p3   <= $signed(prod_p2[2*DW:DW-1]) + dc_ext;
  end

  assign dac_o       = dac_q;
  assign buf_rpnt_o  = addr_p0;
  assign busy_o      = busy_q;
  assign trig_done_o = done_q;

endmodule
